// File: rtl/line_buffer_7x7_pkg.sv
// Shared constants for the 7x7 neighbourhood filter pipeline.
package line_buffer_7x7_pkg;
  localparam int PIXEL_W   = 8;
  localparam int WIN_SIZE  = 7;
  localparam int LB_STAGES = WIN_SIZE - 1;
endpackage

// File: rtl/line_buffer_7x7_row_delay_line.sv
// One-row delay line: circular buffer whose read and write share one pointer,
// so each accepted sample comes back out exactly DEPTH accepts later.
module row_delay_line #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en_i) begin
      if (r_ptr == PW'(DEPTH - 1)) r_ptr <= '0;
      else                         r_ptr <= r_ptr + 1'b1;
    end
  end

  // Storage is deliberately unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (en_i) r_mem[r_ptr] <= data_i;
  end

  assign data_o = r_mem[r_ptr];
endmodule

// File: rtl/line_buffer_7x7.sv
// Seven-row line buffer: six cascaded row delays feed seven registered column
// taps (S1 oldest row, S7 current row) with frame position tracking.
module line_buffer_7x7
  import line_buffer_7x7_pkg::*;
#(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               done_i,
  input  logic [PIXEL_W-1:0] data_i,
  output logic [PIXEL_W-1:0] S1_o,
  output logic [PIXEL_W-1:0] S2_o,
  output logic [PIXEL_W-1:0] S3_o,
  output logic [PIXEL_W-1:0] S4_o,
  output logic [PIXEL_W-1:0] S5_o,
  output logic [PIXEL_W-1:0] S6_o,
  output logic [PIXEL_W-1:0] S7_o,
  output logic               done_o,
  output logic               progress_done_o
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0]      r_col_cnt;
  logic [RW-1:0]      r_row_cnt;
  logic [PIXEL_W-1:0] r_tap [WIN_SIZE];
  logic               r_done;
  logic               r_progress;

  logic [PIXEL_W-1:0] w_line_in  [LB_STAGES];
  logic [PIXEL_W-1:0] w_line_out [LB_STAGES];
  logic               w_last_col;
  logic               w_last_row;

  // Stage LB_STAGES-1 takes the live pixel; each lower stage takes the one above.
  for (genvar g = 0; g < LB_STAGES; g++) begin : g_stage
    if (g == LB_STAGES - 1) begin : g_head
      assign w_line_in[g] = data_i;
    end else begin : g_chain
      assign w_line_in[g] = w_line_out[g+1];
    end
    row_delay_line #(.DEPTH(COLS), .WIDTH(PIXEL_W)) u_row (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (done_i),
      .data_i (w_line_in[g]),
      .data_o (w_line_out[g])
    );
  end

  assign w_last_col = (r_col_cnt == CW'(COLS - 1));
  assign w_last_row = (r_row_cnt == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_progress <= 1'b0;
      for (int k = 0; k < WIN_SIZE; k++) r_tap[k] <= '0;
    end else begin
      r_done     <= 1'b0;
      r_progress <= 1'b0;
      if (done_i) begin
        for (int k = 0; k < LB_STAGES; k++) r_tap[k] <= w_line_out[k];
        r_tap[LB_STAGES] <= data_i;
        // Rows below LB_STAGES only prime the delay lines, which also masks
        // stale data left over from a previous frame.
        r_done     <= (r_row_cnt >= RW'(LB_STAGES));
        r_progress <= w_last_row && w_last_col;
        if (w_last_col) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
    end
  end

  assign S1_o            = r_tap[0];
  assign S2_o            = r_tap[1];
  assign S3_o            = r_tap[2];
  assign S4_o            = r_tap[3];
  assign S5_o            = r_tap[4];
  assign S6_o            = r_tap[5];
  assign S7_o            = r_tap[6];
  assign done_o          = r_done;
  assign progress_done_o = r_progress;
endmodule

// File: tb/tb_line_buffer_7x7.sv
// Scoreboard bench for line_buffer_7x7: expected tap vectors come from frame
// pixel arithmetic and are popped by a monitor whenever done_o is seen.
module tb_line_buffer_7x7;
  localparam int COLS = 8;
  localparam int ROWS = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] s1, s2, s3, s4, s5, s6, s7;
  logic       done_o, progress_done_o;

  line_buffer_7x7 #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .done_i          (done_i),
    .data_i          (data_i),
    .S1_o            (s1),
    .S2_o            (s2),
    .S3_o            (s3),
    .S4_o            (s4),
    .S5_o            (s5),
    .S6_o            (s6),
    .S7_o            (s7),
    .done_o          (done_o),
    .progress_done_o (progress_done_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [55:0] exp_q[$];
  int          drv_row = -1;
  bit          drv_last = 1'b0;
  bit          smp_valid = 1'b0;
  bit          smp_prog = 1'b0;
  int          cnt_done = 0;
  int          cnt_prog = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    int v;
    v = 16 * r + c;
    return (mode != 0) ? 8'(255 - v) : 8'(v);
  endfunction

  // What the DUT should flag for the pixel it is sampling at this edge.
  always @(posedge clk) begin
    smp_valid = rst_n && done_i && (drv_row >= 6);
    smp_prog  = rst_n && done_i && drv_last;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {6'd0, done_o, progress_done_o, s1, s2, s3, s4, s5, s6, s7}, 64'd0);
    end else begin
      check("done_o_timing", {63'd0, done_o}, {63'd0, smp_valid});
      check("progress_timing", {63'd0, progress_done_o}, {63'd0, smp_prog});
      if (progress_done_o) cnt_prog++;
      if (done_o) begin
        cnt_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done_o", 64'd1, 64'd0);
        end else begin
          logic [55:0] e;
          e = exp_q.pop_front();
          check("taps", {8'd0, s1, s2, s3, s4, s5, s6, s7}, {8'd0, e});
        end
      end
    end
  end

  task automatic idle_cycle();
    done_i   = 1'b0;
    drv_last = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int mode, input int r, input int c);
    logic [55:0] e;
    done_i   = 1'b1;
    data_i   = pix(mode, r, c);
    drv_row  = r;
    drv_last = (r == ROWS - 1) && (c == COLS - 1);
    if (r >= 6) begin
      for (int k = 0; k < 7; k++) e[55 - 8*k -: 8] = pix(mode, r - 6 + k, c);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    done_i   = 1'b0;
    drv_last = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit bubbles, input int stop_row, input int stop_col);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bubbles) begin
          while ($urandom_range(1, 0) == 1) idle_cycle();
        end
        drive_pixel(mode, r, c);
        if (r == stop_row && c == stop_col) return;
      end
    end
  endtask

  task automatic check_counts(input string tag, input int want_done, input int want_prog);
    repeat (3) idle_cycle();
    check({tag, "_done_count"}, 64'(cnt_done), 64'(want_done));
    check({tag, "_prog_count"}, 64'(cnt_prog), 64'(want_prog));
    cnt_done = 0;
    cnt_prog = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    done_i = 1'b0;
    data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(0, 1'b0, -1, -1);
    check_counts("basic", (ROWS - 6) * COLS, 1);

    run_frame(0, 1'b1, -1, -1);
    check_counts("bubbles", (ROWS - 6) * COLS, 1);

    run_frame(0, 1'b0, -1, -1);
    run_frame(1, 1'b0, -1, -1);
    check_counts("b2b", 2 * (ROWS - 6) * COLS, 2);

    run_frame(0, 1'b1, 7, 3);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (4) idle_cycle();
    rst_n    = 1'b1;
    cnt_done = 0;
    cnt_prog = 0;

    run_frame(0, 1'b0, -1, -1);
    check_counts("after_reset", (ROWS - 6) * COLS, 1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
